regfile_mp: RTL and testbench

- Parametrised successor to the CPU general-purpose register file.
- Provides 2 asynchronous read ports and 2 synchronous write ports, with register 0 hardwired to zero.
- Adds a per-register pending-write scoreboard for the pipelined core, plus a sequential bulk-clear engine.
- Sits between decode (reads, scoreboard set) and writeback (two retiring results per cycle).

---
 rtl/regfile_mp.sv | 141 ++++++++++++++
 tb/tb_regfile_mp.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: 2R/2W register file with pending-write scoreboard and
// sequential bulk-clear engine. Optional write-first forwarding is
// enabled by defining REGFILE_BYPASS_EN.
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   we0/waddr0/wdata0       write port 0
//   we1/waddr1/wdata1       write port 1 (wins on address collision)
//   raddr0/rdata0/rbusy0    read port 0 (combinational) + busy bit
//   raddr1/rdata1/rbusy1    read port 1 (combinational) + busy bit
//   sb_set/sb_addr          mark a register as having a pending write
//   clr_req/clr_busy        start bulk clear / clear in progress
module regfile_mp #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we0,
   input  logic [ADDR_W-1:0] waddr0,
   input  logic [DATA_W-1:0] wdata0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] waddr1,
   input  logic [DATA_W-1:0] wdata1,
   input  logic [ADDR_W-1:0] raddr0,
   output logic [DATA_W-1:0] rdata0,
   input  logic [ADDR_W-1:0] raddr1,
   output logic [DATA_W-1:0] rdata1,
   output logic              rbusy0,
   output logic              rbusy1,
   input  logic              sb_set,
   input  logic [ADDR_W-1:0] sb_addr,
   input  logic              clr_req,
   output logic              clr_busy
);

   localparam int NUM_REGS = 1 << ADDR_W;

   typedef enum logic {
      S_IDLE,
      S_CLEAR
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   cnt_q, cnt_d;
   logic [DATA_W-1:0]   mem_q [NUM_REGS];
   logic [DATA_W-1:0]   mem_d [NUM_REGS];
   logic [NUM_REGS-1:0] busy_q, busy_d;

   logic [ADDR_W-1:0]   ra [2];
   logic [DATA_W-1:0]   rd [2];
   logic                rb [2];

   // False only for entry 0 when it is hardwired to zero.
   function automatic logic live(input logic [ADDR_W-1:0] a);
      return (ZERO_REG == 0) || (a != '0);
   endfunction

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mem_d   = mem_q;
      busy_d  = busy_q;
      unique case (state_q)
         S_IDLE: begin
            if (we0 && live(waddr0)) begin
               mem_d[waddr0]  = wdata0;
               busy_d[waddr0] = 1'b0;
            end
            // Port 1 is applied last so it wins a collision.
            if (we1 && live(waddr1)) begin
               mem_d[waddr1]  = wdata1;
               busy_d[waddr1] = 1'b0;
            end
            // A newer producer overrides a retiring one.
            if (sb_set && live(sb_addr)) begin
               busy_d[sb_addr] = 1'b1;
            end
            if (clr_req) begin
               state_d = S_CLEAR;
               cnt_d   = (ZERO_REG != 0) ? ADDR_W'(1) : '0;
            end
         end
         S_CLEAR: begin
            mem_d[cnt_q]  = '0;
            busy_d[cnt_q] = 1'b0;
            cnt_d         = cnt_q + ADDR_W'(1);
            if (cnt_q == ADDR_W'(NUM_REGS - 1)) begin
               state_d = S_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         busy_q  <= '0;
         for (int i = 0; i < NUM_REGS; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         mem_q   <= mem_d;
      end
   end

   assign ra[0] = raddr0;
   assign ra[1] = raddr1;

   always_comb begin
      for (int m = 0; m < 2; m++) begin
         rd[m] = mem_q[ra[m]];
         rb[m] = busy_q[ra[m]];
         if (!live(ra[m])) begin
            rd[m] = '0;
            rb[m] = 1'b0;
         end
`ifdef REGFILE_BYPASS_EN
         else if (state_q == S_IDLE && we1 && waddr1 == ra[m]) begin
            rd[m] = wdata1;
            rb[m] = sb_set && (sb_addr == ra[m]);
         end else if (state_q == S_IDLE && we0 && waddr0 == ra[m]) begin
            rd[m] = wdata0;
            rb[m] = sb_set && (sb_addr == ra[m]);
         end
`endif
      end
   end

   assign rdata0   = rd[0];
   assign rdata1   = rd[1];
   assign rbusy0   = rb[0];
   assign rbusy1   = rb[1];
   assign clr_busy = (state_q == S_CLEAR);

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: self-checking bench for regfile_mp at default
// parameters; expected values flow through a scoreboard queue.
module tb_regfile_mp;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        we0 = 1'b0;
   logic [4:0]  waddr0 = '0;
   logic [31:0] wdata0 = '0;
   logic        we1 = 1'b0;
   logic [4:0]  waddr1 = '0;
   logic [31:0] wdata1 = '0;
   logic [4:0]  raddr0 = '0;
   logic [31:0] rdata0;
   logic [4:0]  raddr1 = '0;
   logic [31:0] rdata1;
   logic        rbusy0, rbusy1;
   logic        sb_set = 1'b0;
   logic [4:0]  sb_addr = '0;
   logic        clr_req = 1'b0;
   logic        clr_busy;

   int          pass_cnt = 0;
   int          total_cnt = 0;
   logic [31:0] exp_q [$];

   regfile_mp dut (
      .clk(clk), .rst_n(rst_n),
      .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
      .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
      .raddr0(raddr0), .rdata0(rdata0),
      .raddr1(raddr1), .rdata1(rdata1),
      .rbusy0(rbusy0), .rbusy1(rbusy1),
      .sb_set(sb_set), .sb_addr(sb_addr),
      .clr_req(clr_req), .clr_busy(clr_busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      we0 = 1'b0;
      we1 = 1'b0;
      sb_set = 1'b0;
      clr_req = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] e;
      rst_n = 1'b0;
      raddr0 = 5;
      raddr1 = 31;
      repeat (2) step();
      exp_q.push_back(0); exp_q.push_back(0);
      exp_q.push_back(0); exp_q.push_back(0);
      exp_q.push_back(0);
      e = exp_q.pop_front(); total_cnt++;
      if (rdata0 !== e) $display("FAIL reset_rdata0 got %h want %h", rdata0, e);
      else pass_cnt++;
      e = exp_q.pop_front(); total_cnt++;
      if (rdata1 !== e) $display("FAIL reset_rdata1 got %h want %h", rdata1, e);
      else pass_cnt++;
      e = exp_q.pop_front(); total_cnt++;
      if ({31'd0, rbusy0} !== e) $display("FAIL reset_rbusy0 got %b want %0d", rbusy0, e);
      else pass_cnt++;
      e = exp_q.pop_front(); total_cnt++;
      if ({31'd0, rbusy1} !== e) $display("FAIL reset_rbusy1 got %b want %0d", rbusy1, e);
      else pass_cnt++;
      e = exp_q.pop_front(); total_cnt++;
      if ({31'd0, clr_busy} !== e) $display("FAIL reset_clr_busy got %b want %0d", clr_busy, e);
      else pass_cnt++;
      rst_n = 1'b1;
   endtask

   task automatic test_dual_write();
      logic [31:0] e;
      step();
      we0 = 1; waddr0 = 3; wdata0 = 32'hAAAA0001;
      we1 = 1; waddr1 = 3; wdata1 = 32'h55550002;
      step();
      quiet();
      raddr0 = 3; raddr1 = 3;
      exp_q.push_back(32'h55550002);
      exp_q.push_back(32'h55550002);
      #1;
      e = exp_q.pop_front(); total_cnt++;
      if (rdata0 !== e) $display("FAIL dual_rdata0 got %h want %h", rdata0, e);
      else pass_cnt++;
      e = exp_q.pop_front(); total_cnt++;
      if (rdata1 !== e) $display("FAIL dual_rdata1 got %h want %h", rdata1, e);
      else pass_cnt++;
      we0 = 1; waddr0 = 0; wdata0 = 32'hFFFFFFFF;
      step();
      quiet();
      raddr0 = 0;
      exp_q.push_back(0);
      #1;
      e = exp_q.pop_front(); total_cnt++;
      if (rdata0 !== e) $display("FAIL zero_reg_rdata got %h want %h", rdata0, e);
      else pass_cnt++;
   endtask

   task automatic test_scoreboard();
      logic [31:0] e;
      step();
      sb_set = 1; sb_addr = 7;
      step();
      quiet();
      raddr0 = 7; raddr1 = 8;
      exp_q.push_back(1); exp_q.push_back(0);
      #1;
      e = exp_q.pop_front(); total_cnt++;
      if ({31'd0, rbusy0} !== e) $display("FAIL sb_set_busy got %b want %0d", rbusy0, e);
      else pass_cnt++;
      e = exp_q.pop_front(); total_cnt++;
      if ({31'd0, rbusy1} !== e) $display("FAIL sb_other_busy got %b want %0d", rbusy1, e);
      else pass_cnt++;
      we0 = 1; waddr0 = 7; wdata0 = 32'h00007777;
      step();
      quiet();
      exp_q.push_back(0); exp_q.push_back(32'h00007777);
      #1;
      e = exp_q.pop_front(); total_cnt++;
      if ({31'd0, rbusy0} !== e) $display("FAIL sb_clear_busy got %b want %0d", rbusy0, e);
      else pass_cnt++;
      e = exp_q.pop_front(); total_cnt++;
      if (rdata0 !== e) $display("FAIL sb_clear_data got %h want %h", rdata0, e);
      else pass_cnt++;
      sb_set = 1; sb_addr = 7;
      we1 = 1; waddr1 = 7; wdata1 = 32'h00008888;
      step();
      quiet();
      exp_q.push_back(1); exp_q.push_back(32'h00008888);
      #1;
      e = exp_q.pop_front(); total_cnt++;
      if ({31'd0, rbusy0} !== e) $display("FAIL sb_set_wins got %b want %0d", rbusy0, e);
      else pass_cnt++;
      e = exp_q.pop_front(); total_cnt++;
      if (rdata0 !== e) $display("FAIL sb_set_wins_data got %h want %h", rdata0, e);
      else pass_cnt++;
   endtask

   task automatic test_bypass();
      logic [31:0] e;
      step();
      we0 = 1; waddr0 = 9; wdata0 = 32'h12345678;
      raddr1 = 9;
`ifdef REGFILE_BYPASS_EN
      exp_q.push_back(32'h12345678);
`else
      exp_q.push_back(0);
`endif
      exp_q.push_back(0);
      #1;
      e = exp_q.pop_front(); total_cnt++;
      if (rdata1 !== e) $display("FAIL bypass_same_cycle got %h want %h", rdata1, e);
      else pass_cnt++;
      e = exp_q.pop_front(); total_cnt++;
      if ({31'd0, rbusy1} !== e) $display("FAIL bypass_busy got %b want %0d", rbusy1, e);
      else pass_cnt++;
      step();
      quiet();
      exp_q.push_back(32'h12345678);
      #1;
      e = exp_q.pop_front(); total_cnt++;
      if (rdata1 !== e) $display("FAIL bypass_next_cycle got %h want %h", rdata1, e);
      else pass_cnt++;
   endtask

   task automatic run_clear(input string tag);
      logic [31:0] e;
      int n;
      clr_req = 1;
      step();
      clr_req = 0;
      n = 0;
      while (clr_busy === 1'b1 && n < 100) begin
         n++;
         we0 = (n == 20);
         waddr0 = 5;
         wdata0 = 32'hDEAD0005;
         step();
      end
      we0 = 0;
      exp_q.push_back(31);
      e = exp_q.pop_front(); total_cnt++;
      if (n !== int'(e)) $display("FAIL %s_cycles got %0d want %0d", tag, n, e);
      else pass_cnt++;
   endtask

   task automatic test_bulk_clear();
      logic [31:0] e;
      for (int i = 1; i < 32; i++) begin
         step();
         we0 = 1; waddr0 = 5'(i); wdata0 = 32'hC0DE0000 | i;
         sb_set = 1; sb_addr = 5'(i);
      end
      step();
      quiet();
      raddr0 = 17;
      exp_q.push_back(32'hC0DE0011); exp_q.push_back(1);
      #1;
      e = exp_q.pop_front(); total_cnt++;
      if (rdata0 !== e) $display("FAIL fill_data got %h want %h", rdata0, e);
      else pass_cnt++;
      e = exp_q.pop_front(); total_cnt++;
      if ({31'd0, rbusy0} !== e) $display("FAIL fill_busy got %b want %0d", rbusy0, e);
      else pass_cnt++;
      run_clear("clear");
      for (int a = 0; a < 32; a++) begin
         raddr0 = 5'(a);
         raddr1 = 5'(31 - a);
         exp_q.push_back(0); exp_q.push_back(0);
         #1;
         e = exp_q.pop_front(); total_cnt++;
         if (rdata0 !== e || rdata1 !== e)
            $display("FAIL cleared_data[%0d] got %h/%h want %h", a, rdata0, rdata1, e);
         else pass_cnt++;
         e = exp_q.pop_front(); total_cnt++;
         if ({31'd0, rbusy0} !== e || {31'd0, rbusy1} !== e)
            $display("FAIL cleared_busy[%0d] got %b/%b want %0d", a, rbusy0, rbusy1, e);
         else pass_cnt++;
      end
   endtask

   task automatic test_reset_mid_clear();
      logic [31:0] e;
      step();
      we0 = 1; waddr0 = 20; wdata0 = 32'h0000BEEF;
      sb_set = 1; sb_addr = 20;
      step();
      quiet();
      raddr0 = 20;
      clr_req = 1;
      step();
      clr_req = 0;
      repeat (9) step();
      exp_q.push_back(1); exp_q.push_back(32'h0000BEEF);
      e = exp_q.pop_front(); total_cnt++;
      if ({31'd0, clr_busy} !== e) $display("FAIL mid_clr_busy got %b want %0d", clr_busy, e);
      else pass_cnt++;
      e = exp_q.pop_front(); total_cnt++;
      if (rdata0 !== e) $display("FAIL mid_uncleared got %h want %h", rdata0, e);
      else pass_cnt++;
      rst_n = 0;
      #1;
      exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
      e = exp_q.pop_front(); total_cnt++;
      if ({31'd0, clr_busy} !== e) $display("FAIL rst_clr_busy got %b want %0d", clr_busy, e);
      else pass_cnt++;
      e = exp_q.pop_front(); total_cnt++;
      if (rdata0 !== e) $display("FAIL rst_rdata got %h want %h", rdata0, e);
      else pass_cnt++;
      e = exp_q.pop_front(); total_cnt++;
      if ({31'd0, rbusy0} !== e) $display("FAIL rst_rbusy got %b want %0d", rbusy0, e);
      else pass_cnt++;
      step();
      rst_n = 1;
      step();
      run_clear("restart");
   endtask

   initial begin
      test_reset();
      test_dual_write();
      test_scoreboard();
      test_bypass();
      test_bulk_clear();
      test_reset_mid_clear();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
